wb_uart: RTL and testbench

Wishbone-classic slave UART (8N1) that replaces the simulation-only serial model in the serial-port slot of the data-bus mux (base `32'h20`, two word registers). It buffers transmit bytes from the core in a FIFO, serialises them on `txd`, and optionally deserialises `rxd` into a receive FIFO. It sits directly downstream of the mux's serial-port slave port and drives its `dat_i`/`ack_i` lanes.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_fifo.sv | 61 ++++++
 rtl/wb_uart.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_wb_uart.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the wb_uart slice.
//   - register offsets decoded from adr_i[0]
//   - STATUS bit positions
//   - uart_state_t, the frame state encoding used by both TX and RX
package uart_pkg;

  localparam logic UART_DATA   = 1'b0;
  localparam logic UART_STATUS = 1'b1;

  localparam int ST_TXFULL  = 0;
  localparam int ST_TXEMPTY = 1;
  localparam int ST_RXAVAIL = 2;
  localparam int ST_RXOVR   = 3;
  localparam int ST_FRAMERR = 4;
  localparam int ST_TXDROP  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO, 2**DEPTH_BITS entries of WIDTH bits.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   push_i/wdata_i write strobe and data
//   pop_i          read strobe; rdata_o shows the head entry combinationally
//   full_o/empty_o occupancy flags
// A push while full is accepted when a pop happens on the same edge.
// A pop while empty is ignored.
module uart_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0]  mem_q [2**DEPTH_BITS];
  logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
  logic do_push, do_pop;

  // Pointers carry one extra wrap bit: equal means empty, MSB-only
  // difference means full.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                   (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign rdata_o = mem_q[rd_ptr_q[DEPTH_BITS-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/wb_uart.sv
// wb_uart: Wishbone-classic slave UART, 8N1, two word registers.
//   adr_i[0]=0 DATA   write: push TX byte; read: pop RX {23'b0, valid, byte}
//   adr_i[0]=1 STATUS {26'b0, TXDROP, FRAMERR, RXOVR, RXAVAIL, TXEMPTY, TXFULL}
//                     read clears the sticky bits (3..5)
// Ports:
//   clk, reset            core clock, asynchronous active-low reset
//   adr_i, dat_i, we_i    word address (bit 0 decoded), write data (7:0), write enable
//   sel_i                 ignored, accesses are whole-word
//   stb_i, cyc_i, ack_o   request / single-cycle acknowledge
//   dat_o                 read data, valid while ack_o is high
//   txd                   serial out, idles high
//   rxd                   serial in, asynchronous to clk
// Handshake: a request is sampled when stb_i & cyc_i & ~ack_o; on that edge
// the side effect happens and ack_o rises for exactly one cycle.
// Build option: define UART_RX_EN to build the receive path; without it
// rxd is unused, DATA reads return 0 and STATUS bits 2..4 read 0.
module wb_uart
  import uart_pkg::*;
#(
  parameter int CLKDIV     = 434,
  parameter int DEPTH_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic        txd,
  input  logic        rxd
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKDIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKDIV / 2 - 1);

  // ---------------- bus front end ----------------
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        req, wr_data, rd_data, rd_status;

  assign req       = stb_i & cyc_i & ~ack_q;
  assign wr_data   = req &  we_i & (adr_i[0] == UART_DATA);
  assign rd_data   = req & ~we_i & (adr_i[0] == UART_DATA);
  assign rd_status = req & ~we_i & (adr_i[0] == UART_STATUS);

  // ---------------- TX path ----------------
  logic        tx_full, tx_empty, tx_load;
  logic [7:0]  tx_rdata;
  uart_state_t tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        txd_q;
  logic        tx_cnt_last;

  assign tx_cnt_last = (tx_cnt_q == BIT_LAST);
  // Load from the FIFO when idle, or at the end of STOP for back-to-back frames.
  assign tx_load = ~tx_empty & ((tx_state_q == IDLE) ||
                                ((tx_state_q == STOP) && tx_cnt_last));

  uart_fifo #(.WIDTH(8), .DEPTH_BITS(DEPTH_BITS)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_data),
    .wdata_i (dat_i[7:0]),
    .pop_i   (tx_load),
    .rdata_o (tx_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        IDLE: begin
          if (tx_load) begin
            tx_shift_q <= tx_rdata;
            tx_cnt_q   <= '0;
            tx_state_q <= START;
            txd_q      <= 1'b0;
          end
        end
        START: begin
          if (tx_cnt_last) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= DATA;
            txd_q      <= tx_shift_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (tx_cnt_last) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= STOP;
              txd_q      <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= tx_shift_q >> 1;
              txd_q      <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (tx_cnt_last) begin
            tx_cnt_q <= '0;
            if (tx_load) begin
              tx_shift_q <= tx_rdata;
              tx_state_q <= START;
              txd_q      <= 1'b0;
            end else begin
              tx_state_q <= IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        default: tx_state_q <= IDLE;
      endcase
    end
  end

  assign txd = txd_q;

  // ---------------- RX path ----------------
  logic       rx_empty, rx_full;
  logic [7:0] rx_rdata;
  logic       rx_ovr_set, rx_ferr_set;

`ifdef UART_RX_EN
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_t rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic        rx_stop_sample, rx_pop, rx_push;

  assign rx_stop_sample = (rx_state_q == STOP) && (rx_cnt_q == BIT_LAST);
  assign rx_pop         = rd_data & ~rx_empty;
  // A bus pop on the same edge frees a slot, so a full FIFO can still accept.
  assign rx_push        = rx_stop_sample &  rx_s2_q & (~rx_full | rx_pop);
  assign rx_ovr_set     = rx_stop_sample &  rx_s2_q &   rx_full & ~rx_pop;
  assign rx_ferr_set    = rx_stop_sample & ~rx_s2_q;

  uart_fifo #(.WIDTH(8), .DEPTH_BITS(DEPTH_BITS)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push),
    .wdata_i (rx_shift_q),
    .pop_i   (rx_pop),
    .rdata_o (rx_rdata),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      case (rx_state_q)
        IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= START;
          end
        end
        START: begin
          // Mid-bit check of the start bit; a high level means it was a glitch.
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? IDLE : DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= IDLE;
      endcase
    end
  end
`else
  logic unused_rx;
  assign rx_empty    = 1'b1;
  assign rx_full     = 1'b0;
  assign rx_rdata    = 8'h00;
  assign rx_ovr_set  = 1'b0;
  assign rx_ferr_set = 1'b0;
  assign unused_rx   = rxd ^ rx_full;
`endif

  // ---------------- sticky status ----------------
  logic txdrop_q, rxovr_q, framerr_q;
  logic txdrop_set;

  // Dropped only if no TX load frees a slot on the same edge.
  assign txdrop_set = wr_data & tx_full & ~tx_load;

  // Set wins over the read-clear so a coincident event is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txdrop_q  <= 1'b0;
      rxovr_q   <= 1'b0;
      framerr_q <= 1'b0;
    end else begin
      txdrop_q  <= (txdrop_q  & ~rd_status) | txdrop_set;
      rxovr_q   <= (rxovr_q   & ~rd_status) | rx_ovr_set;
      framerr_q <= (framerr_q & ~rd_status) | rx_ferr_set;
    end
  end

  // ---------------- read mux and ack ----------------
  logic [31:0] status_w;

  always_comb begin
    status_w             = '0;
    status_w[ST_TXFULL]  = tx_full;
    status_w[ST_TXEMPTY] = tx_empty & (tx_state_q == IDLE);
    status_w[ST_RXAVAIL] = ~rx_empty;
    status_w[ST_RXOVR]   = rxovr_q;
    status_w[ST_FRAMERR] = framerr_q;
    status_w[ST_TXDROP]  = txdrop_q;
  end

  always_comb begin
    ack_d = req;
    dat_d = '0;
    if (rd_status)                dat_d = status_w;
    else if (rd_data && !rx_empty) dat_d = {23'b0, 1'b1, rx_rdata};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;

  logic unused_bus;
  assign unused_bus = ^{adr_i[31:1], dat_i[31:8], sel_i};

endmodule

// File: tb/tb_wb_uart.sv
// tb_wb_uart: directed bench for wb_uart with CLKDIV=4, DEPTH_BITS=2.
// TX bytes are queued in exp_q as they are written and checked by a txd
// frame monitor; RX words are queued in rx_exp_q as frames are driven and
// checked on DATA reads. RX scenarios are built when UART_RX_EN is defined.
module tb_wb_uart;

  localparam int CLKDIV     = 4;
  localparam int DEPTH_BITS = 2;
  localparam int PERIOD     = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        we_i = 1'b0;
  logic [3:0]  sel_i = 4'hF;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic        ack_o;
  logic        txd;
  logic        rxd = 1'b1;

  int errors = 0;
  int checks = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rx_exp_q[$];
  logic        tx_abort = 1'b0;

  // ---------------- clock ----------------
  always #(PERIOD/2) clk = ~clk;

  wb_uart #(.CLKDIV(CLKDIV), .DEPTH_BITS(DEPTH_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .we_i  (we_i),
    .sel_i (sel_i),
    .stb_i (stb_i),
    .cyc_i (cyc_i),
    .ack_o (ack_o),
    .txd   (txd),
    .rxd   (rxd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_xfer(input logic we, input logic adr, input logic [31:0] wd,
                          output logic [31:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    stb_i = 1'b1; cyc_i = 1'b1; we_i = we; adr_i = {31'b0, adr}; dat_i = wd;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack_o && n < 8);
    rd = dat_o;
    check("bus_ack", {31'b0, ack_o}, 32'd1);
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] wd);
    logic [31:0] rd;
    bus_xfer(1'b1, 1'b0, wd, rd);
  endtask

  task automatic read_check(input string tag, input logic adr, input logic [31:0] exp);
    logic [31:0] rd;
    bus_xfer(1'b0, adr, 32'h0, rd);
    check(tag, rd, exp);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CLKDIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CLKDIV) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CLKDIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic wait_tx_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); n++;
    end
    check("tx_drain", exp_q.size(), 32'd0);
    repeat (4) @(posedge clk);
  endtask

  // ---------------- txd monitor ----------------
  // Samples each bit one half-cycle after it starts and one half-cycle before
  // it ends, so a bit of the wrong length shows up in one of the two vectors.
  initial begin
    forever begin
      logic [9:0] early, late, exp_frame;
      @(negedge txd);
      #(PERIOD/2);
      for (int k = 0; k < 10; k++) begin
        early[k] = txd;
        #(PERIOD*(CLKDIV-1));
        late[k] = txd;
        if (k < 9) #(PERIOD);
      end
      if (!tx_abort) begin
        if (exp_q.size() != 0) exp_frame = {1'b1, exp_q.pop_front(), 1'b0};
        else                   exp_frame = 10'h3FF;
        check("tx_frame_early", {22'b0, early}, {22'b0, exp_frame});
        check("tx_frame_late",  {22'b0, late},  {22'b0, exp_frame});
      end
    end
  end

  initial begin
    #(PERIOD*50000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [5:0]  pat;
    int          n;

    // Reset
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", {31'b0, txd}, 32'd1);
    check("reset_ack", {31'b0, ack_o}, 32'd0);
    check("reset_dat", dat_o, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    read_check("reset_status", 1'b1, 32'h2);

    // Single TX, with start-bit latency
    exp_q.push_back(8'hA5);
    bus_write(32'h1A5);
    check("tx_idle_at_push", {31'b0, txd}, 32'd1);
    @(posedge clk); #1;
    check("tx_start_latency", {31'b0, txd}, 32'd0);
    wait_tx_drain(200);
    read_check("status_after_tx", 1'b1, 32'h2);

    // TX overflow: 0..4 sent, 5 dropped
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(8'(i));
      bus_write(32'(i));
    end
    n = 0;
    while (exp_q.size() > 4 && n < 200) begin
      @(posedge clk); n++;
    end
    check("tx_first_frame_done", exp_q.size(), 32'd4);
    repeat (3) @(posedge clk);
    read_check("status_txdrop", 1'b1, 32'h20);
    wait_tx_drain(400);
    read_check("status_txdrop_cleared", 1'b1, 32'h2);

    // Ack protocol: held strobe on STATUS
    repeat (2) @(posedge clk);
    @(negedge clk);
    stb_i = 1'b1; cyc_i = 1'b1; we_i = 1'b0; adr_i = 32'h1;
    for (int i = 0; i < 6; i++) begin
      pat[i] = ack_o;
      if (i < 5) @(negedge clk);
    end
    stb_i = 1'b0; cyc_i = 1'b0;
    check("ack_pattern", {26'b0, pat}, 32'b101010);
    repeat (2) @(posedge clk);

`ifdef UART_RX_EN
    // RX loopback
    rx_exp_q.push_back(32'h13C);
    rx_send(8'h3C, 1'b1);
    repeat (4) @(posedge clk);
    read_check("status_rxavail", 1'b1, 32'h6);
    read_check("rx_data_3c", 1'b0, rx_exp_q.pop_front());
    read_check("rx_empty_read", 1'b0, 32'h0);

    // Framing error
    rx_send(8'h55, 1'b0);
    repeat (4) @(posedge clk);
    read_check("status_framerr", 1'b1, 32'h12);
    read_check("rx_framerr_nodata", 1'b0, 32'h0);

    // Overrun: 5 frames into a 4-entry FIFO
    for (int i = 0; i < 5; i++) begin
      if (i < 4) rx_exp_q.push_back(32'h100 | 32'(8'h10 + 8'(i)));
      rx_send(8'h10 + 8'(i), 1'b1);
    end
    repeat (4) @(posedge clk);
    read_check("status_rxovr", 1'b1, 32'hE);
    for (int i = 0; i < 4; i++) read_check("rx_ovr_data", 1'b0, rx_exp_q.pop_front());
    read_check("rx_ovr_drained", 1'b0, 32'h0);

    // Glitch reject
    @(negedge clk); rxd = 1'b0;
    @(negedge clk); rxd = 1'b1;
    repeat (10) @(posedge clk);
    read_check("status_glitch", 1'b1, 32'h2);
    read_check("rx_glitch_nodata", 1'b0, 32'h0);
`else
    // Receive path absent: traffic on rxd has no visible effect
    rx_send(8'h3C, 1'b1);
    repeat (4) @(posedge clk);
    read_check("status_no_rx", 1'b1, 32'h2);
    read_check("data_no_rx", 1'b0, 32'h0);
`endif

    // Reset mid-frame forces txd high at once
    tx_abort = 1'b1;
    bus_write(32'h77);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("tx_in_start_bit", {31'b0, txd}, 32'd0);
    reset = 1'b0;
    #1;
    check("tx_async_reset", {31'b0, txd}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    read_check("status_after_abort", 1'b1, 32'h2);
    check("rx_queue_empty", rx_exp_q.size(), 32'd0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
